x_6k_tap_buffer: RTL and testbench



---
 rtl/x_6k_pkg.sv | 7 +
 rtl/x_6k_phase_counter.sv | 25 ++
 rtl/x_6k_tap_buffer.sv | 87 ++++++++
 tb/tb_x_6k_tap_buffer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/x_6k_pkg.sv
// x_6k_pkg: shared defaults and tap count for the 6-phase polyphase FIR family
package x_6k_pkg;
    localparam int DEF_W_IN   = 7;
    localparam int DEF_PHASES = 6;
    localparam int DEF_K_W    = 16;
    localparam int N_TAPS     = 4;
endpackage

// File: rtl/x_6k_phase_counter.sv
// x_6k_phase_counter: mod-PHASES counter with enable, sync clear and a wrap pulse
module x_6k_phase_counter
    import x_6k_pkg::*;
#(
    parameter int PHASES = DEF_PHASES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        en,
    output logic [$clog2(PHASES)-1:0]   phase,
    output logic                        wrap
);
    localparam int PW = $clog2(PHASES);
    localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

    assign wrap = en && phase == LAST;

    always_ff @(posedge clk) begin
        if (rst || clear)
            phase <= '0;
        else if (en)
            phase <= wrap ? '0 : phase + 1'b1;
    end
endmodule

// File: rtl/x_6k_tap_buffer.sv
// x_6k_tap_buffer: 4-deep sample history emitting a registered tap window once per
// polyphase block, with valid/ready on both the sample input and the window output
module x_6k_tap_buffer
    import x_6k_pkg::*;
#(
    parameter int w_in      = DEF_W_IN,
    parameter int PHASES    = DEF_PHASES,
    parameter int SEL_PHASE = 0,
    parameter int k_w       = DEF_K_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic signed [w_in-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic signed [w_in-1:0] x_6k,
    output logic signed [w_in-1:0] x_6k_1,
    output logic signed [w_in-1:0] x_6k_2,
    output logic signed [w_in-1:0] x_6k_3,
    output logic [k_w-1:0]         out_k,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int PW = $clog2(PHASES);
    localparam logic [PW-1:0] SEL = PW'(SEL_PHASE);
    localparam logic [2:0] FULL = 3'(N_TAPS);

    logic [PW-1:0]          phase;
    logic                   wrap;
    logic                   accept;
    logic                   emit;
    logic [2:0]             fill;
    logic [k_w-1:0]         k;
    logic signed [w_in-1:0] h [N_TAPS-1];

    // a held window stalls the input so it can never be overwritten
    assign in_ready = !clear && !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign emit     = accept && phase == SEL && fill >= FULL - 3'd1;

    x_6k_phase_counter #(.PHASES(PHASES)) u_phase (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (accept),
        .phase (phase),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            h         <= '{default: '0};
            fill      <= '0;
            k         <= '0;
            x_6k      <= '0;
            x_6k_1    <= '0;
            x_6k_2    <= '0;
            x_6k_3    <= '0;
            out_k     <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            fill      <= '0;
            k         <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                h[0] <= in_data;
                for (int i = 1; i < N_TAPS - 1; i++)
                    h[i] <= h[i-1];
                fill <= fill == FULL ? fill : fill + 3'd1;
                if (wrap)
                    k <= k + 1'b1;
            end
            if (emit) begin
                x_6k      <= in_data;
                x_6k_1    <= h[0];
                x_6k_2    <= h[1];
                x_6k_3    <= h[2];
                out_k     <= k;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_x_6k_tap_buffer.sv
// tb_x_6k_tap_buffer: directed and randomized checks against a sample-index model
module tb_x_6k_tap_buffer;
    localparam int PH  = 6;
    localparam int SEL = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic signed [6:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [6:0] x_6k, x_6k_1, x_6k_2, x_6k_3;
    logic [15:0]       out_k;
    logic              out_valid;
    logic              out_ready = 1'b1;

    int vecs = 0;
    int errs = 0;

    // model: every accepted sample since the last restart, plus the pending window
    int s[$];
    bit mv = 1'b0;
    int mw[4] = '{0, 0, 0, 0};
    int mk = 0;

    x_6k_tap_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_6k      (x_6k),
        .x_6k_1    (x_6k_1),
        .x_6k_2    (x_6k_2),
        .x_6k_3    (x_6k_3),
        .out_k     (out_k),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit iv, input int d, input bit ordy, input bit clr, input bit rs, output bit acc);
        bit exp_rdy;
        int n;
        in_valid  = iv;
        in_data   = 7'(d);
        out_ready = ordy;
        clear     = clr;
        rst       = rs;
        #1;
        exp_rdy = !clr && !(mv && !ordy);
        if (!rs) chk("in_ready", in_ready, exp_rdy);
        acc = 1'b0;
        if (rs || clr) begin
            s.delete();
            mv = 1'b0;
            if (rs) begin
                mw = '{0, 0, 0, 0};
                mk = 0;
            end
        end else begin
            acc = iv && exp_rdy;
            if (acc) s.push_back(d);
            n = s.size() - 1;
            if (acc && n % PH == SEL && n >= 3) begin
                mv = 1'b1;
                for (int j = 0; j < 4; j++) mw[j] = s[n-j];
                mk = (n / PH) % 65536;
            end else if (ordy) begin
                mv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, mv);
        if (mv || rs) begin
            chk("x_6k", x_6k, mw[0]);
            chk("x_6k_1", x_6k_1, mw[1]);
            chk("x_6k_2", x_6k_2, mw[2]);
            chk("x_6k_3", x_6k_3, mw[3]);
            chk("out_k", out_k, mk);
        end
        if (rs) chk("in_ready_after_rst", in_ready, !clr);
    endtask

    task automatic send(input int d, input bit ordy);
        bit acc;
        for (int t = 0; t < 100; t++) begin
            cyc(1'b1, d, ordy, 1'b0, 1'b0, acc);
            if (acc) return;
        end
        errs++;
        $error("FAIL send_timeout: sample %0d not accepted within 100 cycles", d);
    endtask

    task automatic reset_dut();
        bit acc;
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, acc);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, acc);
    endtask

    task automatic window_is(input string tag, input int a, input int b, input int c, input int e, input int kk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_x0"}, x_6k, a);
        chk({tag, "_x1"}, x_6k_1, b);
        chk({tag, "_x2"}, x_6k_2, c);
        chk({tag, "_x3"}, x_6k_3, e);
        chk({tag, "_k"}, out_k, kk);
    endtask

    initial begin
        bit acc;
        int v;
        bit done;
        reset_dut();

        // free-running stream 1..13
        for (int i = 1; i <= 13; i++) begin
            send(i, 1'b1);
            if (i == 7) window_is("stream_w0", 7, 6, 5, 4, 1);
            if (i == 13) window_is("stream_w1", 13, 12, 11, 10, 2);
        end

        // back-pressure holds the window and stalls sample 8
        reset_dut();
        for (int i = 1; i <= 6; i++) send(i, 1'b1);
        send(7, 1'b0);
        for (int t = 0; t < 3; t++) begin
            cyc(1'b1, 8, 1'b0, 1'b0, 1'b0, acc);
            window_is("hold", 7, 6, 5, 4, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        cyc(1'b1, 8, 1'b1, 1'b0, 1'b0, acc);
        chk("release_consumed", out_valid, 0);

        // extreme values pass through bit-exactly
        reset_dut();
        foreach (mw[j]) ;
        send(5, 1'b1); send(5, 1'b1); send(5, 1'b1);
        send(0, 1'b1); send(-1, 1'b1); send(63, 1'b1); send(-64, 1'b1);
        window_is("extreme", -64, 63, -1, 0, 1);

        // clear drops a pending window and restarts indexing
        reset_dut();
        for (int i = 1; i <= 6; i++) send(i, 1'b1);
        send(7, 1'b0);
        cyc(1'b1, 99, 1'b0, 1'b1, 1'b0, acc);
        chk("clear_drop", out_valid, 0);
        for (int i = 1; i <= 7; i++) send(i, 1'b1);
        window_is("after_clear", 7, 6, 5, 4, 1);

        // reset with a pending window and a presented sample
        reset_dut();
        for (int i = 1; i <= 6; i++) send(i, 1'b1);
        send(7, 1'b0);
        cyc(1'b1, 55, 1'b0, 1'b0, 1'b1, acc);
        for (int i = 1; i <= 7; i++) send(i, 1'b1);
        window_is("after_rst", 7, 6, 5, 4, 1);

        // randomized handshakes on both sides
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            v = int'($urandom_range(0, 127)) - 64;
            done = 1'b0;
            for (int t = 0; t < 100 && !done; t++) begin
                cyc($urandom_range(0, 9) < 7, v, 1'($urandom_range(0, 1)), 1'b0, 1'b0, acc);
                done = acc;
            end
            if (!done) begin
                errs++;
                $error("FAIL random_timeout: sample %0d not accepted within 100 cycles", i);
            end
        end
        chk("random_count", s.size(), 600);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
